// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator core; drives the ALU, the data/IO bus and a call stack.
// Optional CONTROL_SEQ_STACK_CHECK_EN: stack over/underflow raises a sticky fault and halts the core.
module control_sequencer #(
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [8+WIDTH-1:0]    imem_data,
  output logic [7:0]            alu_op,
  output logic [WIDTH-1:0]      alu_in1,
  output logic [WIDTH-1:0]      alu_in2,
  input  logic [WIDTH-1:0]      alu_out,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic                  bus_io,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0]      bus_wdata,
  input  logic [WIDTH-1:0]      bus_rdata,
  input  logic                  bus_ack,
  output logic [WIDTH-1:0]      acc,
  output logic                  fault
);
  localparam logic [7:0] OP_NOP = 8'h00, OP_NOT = 8'h01, OP_XOR = 8'h02, OP_OR  = 8'h03,
                         OP_AND = 8'h04, OP_SUB = 8'h05, OP_ADD = 8'h06, OP_RR  = 8'h07,
                         OP_RL  = 8'h08, OP_DEC = 8'h09, OP_INC = 8'h0A, OP_LDI = 8'h0B,
                         OP_RST = 8'h0C, OP_LD  = 8'h10, OP_ST  = 8'h11, OP_IOR = 8'h12,
                         OP_IOW = 8'h13, OP_JMP = 8'h20, OP_JMA = 8'h21, OP_CLL = 8'h22,
                         OP_RET = 8'h23;
  localparam int SPW = $clog2(STACK_DEPTH);
  localparam int CW  = $clog2(STACK_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_BUS, S_HALT} state_t;
  state_t state, nstate;

  logic [ADDR_WIDTH-1:0] pc, pc_nxt, d_tgt;
  logic [7:0]            ir_op, d_op;
  logic [WIDTH-1:0]      ir_arg, d_arg;
  logic [SPW-1:0]        sp, sp_m1;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] stk [STACK_DEPTH];
  logic pc_ld, acc_ld, push, pop, bus_start, bus_done;
`ifdef CONTROL_SEQ_STACK_CHECK_EN
  logic stk_err;
`endif

  function automatic logic is_alu(input logic [7:0] op);
    case (op)
      OP_NOT, OP_XOR, OP_OR, OP_AND, OP_SUB, OP_ADD, OP_RR,
      OP_RL, OP_DEC, OP_INC, OP_LDI, OP_RST: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic is_bus(input logic [7:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_IOR) || (op == OP_IOW);
  endfunction

  assign d_op      = imem_data[8+WIDTH-1:WIDTH];
  assign d_arg     = imem_data[WIDTH-1:0];
  assign d_tgt     = d_arg[ADDR_WIDTH-1:0];
  assign sp_m1     = sp - 1'b1;
  assign imem_addr = pc;
  assign alu_in1   = acc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nstate;
  end

  always_comb begin
    nstate    = state;
    pc_ld     = 1'b0;
    pc_nxt    = pc + 1'b1;
    acc_ld    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    bus_start = 1'b0;
    bus_done  = 1'b0;
    alu_op    = OP_NOP;
    alu_in2   = '0;
`ifdef CONTROL_SEQ_STACK_CHECK_EN
    stk_err   = 1'b0;
`endif
    case (state)
      S_FETCH: nstate = S_DECODE;
      S_DECODE: begin
        nstate = S_FETCH;
        if (is_alu(d_op)) begin
          nstate = S_EXEC;
        end else if (is_bus(d_op)) begin
          nstate    = S_BUS;
          bus_start = 1'b1;
        end else begin
          pc_ld = 1'b1;
          case (d_op)
            OP_JMP: pc_nxt = d_tgt;
            OP_JMA: if (acc == '0) pc_nxt = d_tgt;
            OP_CLL: begin push = 1'b1; pc_nxt = d_tgt;     end
            OP_RET: begin pop  = 1'b1; pc_nxt = stk[sp_m1]; end
            default: ;
          endcase
`ifdef CONTROL_SEQ_STACK_CHECK_EN
          // Faulting call/return leaves pc and stack exactly as they were
          if ((push && cnt == FULL) || (pop && cnt == '0)) begin
            stk_err = 1'b1;
            push    = 1'b0;
            pop     = 1'b0;
            pc_ld   = 1'b0;
            nstate  = S_HALT;
          end
`endif
        end
      end
      S_EXEC: begin
        alu_op  = ir_op;
        alu_in2 = ir_arg;
        acc_ld  = 1'b1;
        pc_ld   = 1'b1;
        nstate  = S_FETCH;
      end
      S_BUS: if (bus_ack) begin
        bus_done = 1'b1;
        pc_ld    = 1'b1;
        nstate   = S_FETCH;
        if (!bus_we) begin
          alu_op  = ir_op;
          alu_in2 = bus_rdata;
          acc_ld  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      acc       <= '0;
      ir_op     <= OP_NOP;
      ir_arg    <= '0;
      sp        <= '0;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_io    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      if (state == S_DECODE) begin
        ir_op  <= d_op;
        ir_arg <= d_arg;
      end
      if (pc_ld)  pc  <= pc_nxt;
      if (acc_ld) acc <= alu_out;
      // Count saturates both ways; sp wraps so an overflowing push drops the oldest entry
      if (push) begin
        sp <= sp + 1'b1;
        if (cnt != FULL) cnt <= cnt + 1'b1;
      end
      if (pop) begin
        sp <= sp_m1;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (bus_start) begin
        bus_req   <= 1'b1;
        bus_we    <= (d_op == OP_ST)  || (d_op == OP_IOW);
        bus_io    <= (d_op == OP_IOR) || (d_op == OP_IOW);
        bus_addr  <= d_tgt;
        bus_wdata <= acc;
      end else if (bus_done) begin
        bus_req <= 1'b0;
        bus_we  <= 1'b0;
        bus_io  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk[sp] <= pc + 1'b1;
  end

`ifdef CONTROL_SEQ_STACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)          fault <= 1'b0;
    else if (stk_err) fault <= 1'b1;
  end
`else
  assign fault = 1'b0;
`endif

endmodule
